// File: rtl/lightsaber_length_ctrl.sv
// lightsaber_length_ctrl: ramps blade length (metres + hundredths) toward commanded targets
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_int/cmd_dec command handshake;
// abort forces retract to 0.00; len_int/len_dec current length; busy/done/err/lit status.
// Define LSABER_INSTANT_RETRACT_EN to make abort zero the length in one edge instead of ramping.
module lightsaber_length_ctrl #(
  parameter int STEP = 5,
  parameter int TICK_DIV = 4,
  parameter int MAX_LEN = 399
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_int,
  input  logic [6:0] cmd_dec,
  input  logic       abort,
  output logic [1:0] len_int,
  output logic [6:0] len_dec,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       lit
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, EXTEND, RETRACT} state_e;
  state_e state_q;
  logic [1:0] len_int_q, tgt_int_q, cmd_int_t, req_int, ext_int, ret_int, step_int_d;
  logic [6:0] len_dec_q, tgt_dec_q, cmd_dec_t, req_dec, ext_dec, ret_dec, step_dec_d;
  logic [9:0] cur_l, tgt_l, cmd_l, req_l;
  logic [7:0] dec_sum;
  logic [CW-1:0] cnt_q;
  logic done_q, err_q, cmd_clip, up_carry, borrow, step_hit, tick;
  assign cur_l = 10'(len_int_q) * 10'd100 + 10'(len_dec_q);
  assign tgt_l = 10'(tgt_int_q) * 10'd100 + 10'(tgt_dec_q);
  assign cmd_l = 10'(cmd_int) * 10'd100 + 10'(cmd_dec);
  // targets beyond the blade's reach clip to MAX_LEN
  assign cmd_clip = cmd_l > 10'(MAX_LEN);
  assign cmd_int_t = cmd_clip ? 2'(MAX_LEN / 100) : cmd_int;
  assign cmd_dec_t = cmd_clip ? 7'(MAX_LEN % 100) : cmd_dec;
  // retract ignores the command fields and always aims at 0.00
  assign req_int = cmd_op == 2'b10 ? 2'd0 : cmd_int_t;
  assign req_dec = cmd_op == 2'b10 ? 7'd0 : cmd_dec_t;
  assign req_l = 10'(req_int) * 10'd100 + 10'(req_dec);
  // field-wise step with carry into / borrow from the integer metres
  assign dec_sum = {1'b0, len_dec_q} + 8'(STEP);
  assign up_carry = dec_sum >= 8'd100;
  assign ext_int = len_int_q + 2'(up_carry);
  assign ext_dec = up_carry ? 7'(dec_sum - 8'd100) : dec_sum[6:0];
  assign borrow = len_dec_q < 7'(STEP);
  assign ret_int = len_int_q - 2'(borrow);
  assign ret_dec = borrow ? 7'({1'b0, len_dec_q} + 8'(100 - STEP)) : len_dec_q - 7'(STEP);
  // a step that would reach or pass the target lands exactly on it
  assign step_hit = state_q == EXTEND ? cur_l + 10'(STEP) >= tgt_l : cur_l <= tgt_l + 10'(STEP);
  assign step_int_d = step_hit ? tgt_int_q : state_q == EXTEND ? ext_int : ret_int;
  assign step_dec_d = step_hit ? tgt_dec_q : state_q == EXTEND ? ext_dec : ret_dec;
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  assign cmd_ready = state_q == IDLE && !abort;
  assign len_int = len_int_q;
  assign len_dec = len_dec_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign lit = cur_l != 10'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_int_q <= '0;
      len_dec_q <= '0;
      tgt_int_q <= '0;
      tgt_dec_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      if (abort) begin
        tgt_int_q <= '0;
        tgt_dec_q <= '0;
        cnt_q <= '0;
`ifdef LSABER_INSTANT_RETRACT_EN
        len_int_q <= '0;
        len_dec_q <= '0;
        done_q <= cur_l != 10'd0;
        state_q <= IDLE;
`else
        state_q <= cur_l != 10'd0 ? RETRACT : IDLE;
`endif
      end else if (state_q == IDLE) begin
        if (cmd_valid && cmd_op != 2'b00) begin
          if (cmd_op != 2'b10 && cmd_dec > 7'd99) begin
            err_q <= 1'b1;
          end else if (cmd_op == 2'b11) begin
            len_int_q <= cmd_int_t;
            len_dec_q <= cmd_dec_t;
            done_q <= 1'b1;
          end else begin
            tgt_int_q <= req_int;
            tgt_dec_q <= req_dec;
            cnt_q <= '0;
            done_q <= req_l == cur_l;
            state_q <= req_l > cur_l ? EXTEND : req_l < cur_l ? RETRACT : IDLE;
          end
        end
      end else if (tick) begin
        len_int_q <= step_int_d;
        len_dec_q <= step_dec_d;
        cnt_q <= '0;
        if (step_hit) begin
          done_q <= 1'b1;
          state_q <= IDLE;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule
